// File: rtl/pusch_re_slot_scheduler.sv
// PUSCH RE mapper slot sequencer: checks and latches a slot config, then
// issues DMRS/FFT symbol starts paced by the mapper's symbol-done edge.
module pusch_re_slot_scheduler #(
    parameter int NUM_SYM  = 14,
    parameter int TIMEOUT  = 4096,
    parameter int TO_W     = 13,
    parameter int TOTAL_SC = 1200
) (
    input  logic        CLK_RE,
    input  logic        RST_RE,
    input  logic        Cfg_Valid,
    output logic        Cfg_Ready,
    input  logic [10:0] Cfg_N_sc,
    input  logic [6:0]  Cfg_N_rb,
    input  logic [3:0]  Cfg_Sym_Start,
    input  logic [3:0]  Cfg_Sym_End,
    output logic        Cfg_Err,
    output logic [10:0] N_sc,
    output logic [6:0]  N_rb,
    output logic [3:0]  Sym_Start,
    output logic [3:0]  Sym_End,
    output logic        Dmrs_Start,
    output logic        Fft_Start,
    output logic [3:0]  Sym_Idx,
    input  logic        Sym_Done,
    input  logic        Abort,
    input  logic        Err_Clr,
    output logic        Busy,
    output logic        Slot_Done,
    output logic        Slot_Err
);

    typedef enum logic [2:0] {
        IDLE,
        DMRS_REQ,
        DMRS_WAIT,
        DATA_REQ,
        DATA_WAIT,
        DONE,
        ERROR
    } state_t;

    state_t state, state_n;

    logic            sym_done_d;
    logic [TO_W-1:0] wdog;
    logic            ev;
    logic            wd_exp;
    logic [11:0]     cfg_end;
    logic            cfg_bad;
    logic            accept;
    logic            reject;
    logic            idx_inc;
    logic            cfg_err_q;

    assign ev     = Sym_Done & ~sym_done_d;
    assign wd_exp = (wdog == TO_W'(TIMEOUT - 1));

    // 12 bits covers the worst case 2047 + 127*12
    assign cfg_end = {1'b0, Cfg_N_sc} + (12'(Cfg_N_rb) * 12'd12);
    assign cfg_bad = (Cfg_N_rb == 7'd0)
                   | (Cfg_Sym_End < Cfg_Sym_Start)
                   | (Cfg_Sym_End > 4'(NUM_SYM - 1))
                   | (cfg_end > 12'(TOTAL_SC));

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        idx_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (Cfg_Valid) begin
                    if (cfg_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = DMRS_REQ;
                    end
                end
            end
            DMRS_REQ: state_n = DMRS_WAIT;
            DATA_REQ: state_n = DATA_WAIT;
            DMRS_WAIT, DATA_WAIT: begin
                // a completing symbol beats a simultaneous watchdog expiry
                if (ev) begin
                    if (Sym_Idx == Sym_End) begin
                        state_n = DONE;
                    end else begin
                        idx_inc = 1'b1;
                        state_n = DATA_REQ;
                    end
                end else if (wd_exp) begin
                    state_n = ERROR;
                end
            end
            DONE: state_n = IDLE;
            ERROR: begin
                if (Err_Clr) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (Abort && state != IDLE) begin
            state_n = IDLE;
            idx_inc = 1'b0;
        end
    end

    always_ff @(posedge CLK_RE or negedge RST_RE) begin
        if (!RST_RE) begin
            state      <= IDLE;
            sym_done_d <= 1'b0;
            wdog       <= '0;
            cfg_err_q  <= 1'b0;
            N_sc       <= '0;
            N_rb       <= '0;
            Sym_Start  <= '0;
            Sym_End    <= '0;
            Sym_Idx    <= '0;
        end else begin
            state      <= state_n;
            sym_done_d <= Sym_Done;
            cfg_err_q  <= reject;
            if (state == DMRS_WAIT || state == DATA_WAIT) begin
                wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
            if (accept) begin
                N_sc      <= Cfg_N_sc;
                N_rb      <= Cfg_N_rb;
                Sym_Start <= Cfg_Sym_Start;
                Sym_End   <= Cfg_Sym_End;
                Sym_Idx   <= Cfg_Sym_Start;
            end else if (idx_inc) begin
                Sym_Idx <= Sym_Idx + 4'd1;
            end
        end
    end

    assign Cfg_Ready  = (state == IDLE);
    assign Busy       = (state != IDLE);
    assign Dmrs_Start = (state == DMRS_REQ);
    assign Fft_Start  = (state == DATA_REQ);
    assign Slot_Done  = (state == DONE);
    assign Slot_Err   = (state == ERROR);
    assign Cfg_Err    = cfg_err_q;

endmodule
